// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave modport; the byte source and imem use master.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: takes a little-endian word count followed by that many
// instruction words, writes them to imem and then releases the core from reset.
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  prog_loader_if.slave       bus,
  output logic               core_reset,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic [ADDR_W:0]   wordIdx_q, wordIdx_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       wordBuf_q, wordBuf_d;
  logic              imemWe_q, imemWe_d;
  logic [31:0]       imemAddr_q, imemAddr_d;
  logic [31:0]       imemWdata_q, imemWdata_d;

  logic              rxReady;
  logic              accept;
  logic [31:0]       fullWord;
  logic              badCount;

  assign rxReady  = (state_q == S_HDR) || (state_q == S_LOAD);
  assign accept   = bus.rx_valid && rxReady;
  // The 4th byte is used straight off the bus so the word is complete on its accept cycle.
  assign fullWord = {bus.rx_data, wordBuf_q[23:0]};
  // 33-bit compare keeps a count near 2**32 from wrapping past the capacity check.
  assign badCount = (fullWord == 32'd0) ||
                    ({1'b0, fullWord} > (33'd1 << ADDR_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_HDR;
      byteIdx_q   <= 2'd0;
      wordIdx_q   <= '0;
      count_q     <= 32'd0;
      wordBuf_q   <= 32'd0;
      imemWe_q    <= 1'b0;
      imemAddr_q  <= 32'd0;
      imemWdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      byteIdx_q   <= byteIdx_d;
      wordIdx_q   <= wordIdx_d;
      count_q     <= count_d;
      wordBuf_q   <= wordBuf_d;
      imemWe_q    <= imemWe_d;
      imemAddr_q  <= imemAddr_d;
      imemWdata_q <= imemWdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byteIdx_d   = byteIdx_q;
    wordIdx_d   = wordIdx_q;
    count_d     = count_q;
    wordBuf_d   = wordBuf_q;
    imemWe_d    = 1'b0;
    imemAddr_d  = imemAddr_q;
    imemWdata_d = imemWdata_q;

    if (accept) begin
      wordBuf_d[8*byteIdx_q +: 8] = bus.rx_data;
      byteIdx_d = byteIdx_q + 2'd1;
    end

    unique case (state_q)
      S_HDR: begin
        if (accept && (byteIdx_q == 2'd3)) begin
          if (badCount) begin
            state_d = S_ERR;
          end else begin
            state_d   = S_LOAD;
            count_d   = fullWord;
            wordIdx_d = '0;
          end
        end
      end
      S_LOAD: begin
        if (accept && (byteIdx_q == 2'd3)) begin
          imemWe_d    = 1'b1;
          imemWdata_d = fullWord;
          imemAddr_d  = {{(30-ADDR_W){1'b0}}, wordIdx_q[ADDR_W-1:0], 2'b00};
          wordIdx_d   = wordIdx_q + 1'b1;
          if (32'(wordIdx_q) == (count_q - 32'd1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_HDR;
    endcase
  end

  assign bus.rx_ready   = rxReady;
  assign bus.imem_we    = imemWe_q;
  assign bus.imem_addr  = imemAddr_q;
  assign bus.imem_wdata = imemWdata_q;
  assign core_reset     = (state_q != S_RUN);
  assign done           = (state_q == S_RUN);
  assign error          = (state_q == S_ERR);

endmodule
